// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO result registers.
// 32-step shift-add multiply and restoring divide on operand magnitudes, followed by a sign-fix cycle.
module mdu_hilo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] acc_hi, acc_hi_nxt;
   logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
   logic [WIDTH-1:0] mag_b, mag_b_nxt;
   logic [WIDTH-1:0] hi_q, hi_nxt;
   logic [WIDTH-1:0] lo_q, lo_nxt;
   logic             busy_q, busy_nxt;
   logic             is_div, is_div_nxt;
   logic             neg_a, neg_a_nxt;
   logic             neg_b, neg_b_nxt;
   logic             div_zero, div_zero_nxt;

   logic               sgn_op;
   logic [WIDTH-1:0]   mag_a_in, mag_b_in;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Operand magnitudes; the most negative value maps to itself as an unsigned magnitude.
   assign sgn_op   = ~op[0];
   assign mag_a_in = (sgn_op && A[WIDTH-1]) ? -A : A;
   assign mag_b_in = (sgn_op && B[WIDTH-1]) ? -B : B;

   // Datapath: acc_hi holds the running product high half / partial remainder,
   // acc_lo holds the multiplier / dividend being shifted out (quotient shifting in).
   assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_b : {WIDTH{1'b0}})};
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, mag_b};
   assign prod      = {acc_hi, acc_lo};
   assign prod_neg  = -prod;
   assign quo_fix   = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
   assign rem_fix   = neg_a ? -acc_hi : acc_hi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         mag_b    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         is_div   <= 1'b0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         acc_hi   <= acc_hi_nxt;
         acc_lo   <= acc_lo_nxt;
         mag_b    <= mag_b_nxt;
         hi_q     <= hi_nxt;
         lo_q     <= lo_nxt;
         busy_q   <= busy_nxt;
         is_div   <= is_div_nxt;
         neg_a    <= neg_a_nxt;
         neg_b    <= neg_b_nxt;
         div_zero <= div_zero_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      acc_hi_nxt   = acc_hi;
      acc_lo_nxt   = acc_lo;
      mag_b_nxt    = mag_b;
      hi_nxt       = hi_q;
      lo_nxt       = lo_q;
      busy_nxt     = busy_q;
      is_div_nxt   = is_div;
      neg_a_nxt    = neg_a;
      neg_b_nxt    = neg_b;
      div_zero_nxt = div_zero;

      unique case (state)
         IDLE: begin
            if (start) begin
               if (!op[2]) begin
                  acc_hi_nxt   = '0;
                  acc_lo_nxt   = mag_a_in;
                  mag_b_nxt    = mag_b_in;
                  is_div_nxt   = op[1];
                  neg_a_nxt    = sgn_op & A[WIDTH-1];
                  neg_b_nxt    = sgn_op & B[WIDTH-1];
                  div_zero_nxt = (B == '0);
                  cnt_nxt      = '0;
                  state_nxt    = RUN;
                  busy_nxt     = 1'b1;
               end else if (op[1:0] == 2'b00) begin
                  hi_nxt = A;
               end else if (op[1:0] == 2'b01) begin
                  lo_nxt = A;
               end
            end
         end

         RUN: begin
            if (is_div) begin
               // Restoring step: keep the difference only when it is non-negative.
               if (!div_diff[WIDTH]) begin
                  acc_hi_nxt = div_diff[WIDTH-1:0];
                  acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_nxt = div_shift[WIDTH-1:0];
                  acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_hi_nxt = mul_sum[WIDTH:1];
               acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == LAST) begin
               state_nxt = FIX;
            end
         end

         FIX: begin
            if (is_div) begin
               // Divide by zero leaves |A| as remainder; re-signing restores the original dividend.
               lo_nxt = div_zero ? {WIDTH{1'b1}} : quo_fix;
               hi_nxt = rem_fix;
            end else if (neg_a ^ neg_b) begin
               {hi_nxt, lo_nxt} = prod_neg;
            end else begin
               {hi_nxt, lo_nxt} = prod;
            end
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end

         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
